// File: rtl/jtopl_wrseq.sv
// CPU write sequencer for the OPL register file: queues data-port writes, decodes the
// register map into per-slot update strobes and holds each update for a full slot scan.
module jtopl_wrseq #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       zero,
  input  logic [7:0] cpu_din,
  input  logic       cpu_addr,
  input  logic       cpu_wr,
  output logic       busy,
  output logic       ovf,
  output logic       write,
  output logic [7:0] dout,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_wav,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_fbcon,
  output logic       wave_mode,
  output logic       rhy_en,
  output logic [4:0] rhy_kon
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0]  HOLD_LAST = 5'd17;

  typedef enum logic [1:0] {IDLE, DECODE, SYNC, HOLD} state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] up;
    logic [1:0] grp;
    logic [2:0] sub;
  } dec_t;

  // up bit order: mult, ksl_tl, ar_dr, sl_rr, wav, fnumlo, fnumhi, fbcon
  function automatic dec_t decode_idx(input logic [7:0] idx);
    dec_t       d;
    logic [4:0] off;
    logic [3:0] ch;
    d   = '0;
    off = idx[4:0];
    ch  = idx[3:0];
    case (idx[7:4])
      4'hA, 4'hB, 4'hC: begin
        if (ch <= 4'd8) begin
          d.up  = 8'h20 << (idx[7:4] - 4'hA);
          d.grp = 2'(ch / 4'd3);
          d.sub = 3'(ch % 4'd3);
        end
      end
      default: begin
        if (off <= 5'h15 && off[2:0] <= 3'd5) begin
          case (idx[7:5])
            3'd1:    d.up = 8'h01;
            3'd2:    d.up = 8'h02;
            3'd3:    d.up = 8'h04;
            3'd4:    d.up = 8'h08;
            3'd7:    d.up = 8'h10;
            default: d.up = 8'h00;
          endcase
          d.grp = off[4:3];
          d.sub = off[2:0];
        end
      end
    endcase
    d.valid = |d.up;
    return d;
  endfunction

  state_t        state, state_nx;
  logic [7:0]    index;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          push, pop, push_ok, fifo_full;
  logic [15:0]   head;
  dec_t          head_dec;
  logic [7:0]    ridx_p0, rdat_p0;
  dec_t          dec_p0;
  logic [4:0]    hold_cnt;
  logic [7:0]    up;

  assign push      = cpu_wr & cpu_addr;
  assign fifo_full = (fifo_cnt == FULL_CNT);
  assign pop       = (state == IDLE) && (fifo_cnt != '0);
  // A full FIFO still accepts a push on the clock it is being popped
  assign push_ok   = push && (!fifo_full || pop);
  assign head      = mem[rd_ptr];
  assign head_dec  = decode_idx(head[15:8]);
  assign busy      = (fifo_cnt != '0) || (state != IDLE);

  assign {up_fbcon, up_fnumhi, up_fnumlo, up_wav,
          up_sl_rr, up_ar_dr, up_ksl_tl, up_mult} = up;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fifo_cnt != '0) state_nx = DECODE;
      DECODE:  state_nx = dec_p0.valid ? SYNC : IDLE;
      SYNC:    if (cen && zero) state_nx = HOLD;
      HOLD:    if (cen && hold_cnt == HOLD_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FIFO storage and pop stage registers (data only)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {index, cpu_din};
    if (pop) begin
      ridx_p0 <= head[15:8];
      rdat_p0 <= head[7:0];
      dec_p0  <= head_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index     <= '0;
      ovf       <= 1'b0;
      write     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      hold_cnt  <= '0;
      up        <= '0;
      dout      <= '0;
      sel_group <= '0;
      sel_sub   <= '0;
      wave_mode <= 1'b0;
      rhy_en    <= 1'b0;
      rhy_kon   <= '0;
    end else begin
      write <= 1'b0;
      if (cpu_wr && !cpu_addr) index <= cpu_din;
      if (push && !push_ok)    ovf   <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      case (state)
        IDLE: if (pop) write <= head_dec.valid;
        // decode stage: globals commit here, slot updates arm their strobe
        DECODE: begin
          if (ridx_p0 == 8'h01) wave_mode <= rdat_p0[5];
          if (ridx_p0 == 8'hBD) begin
            rhy_en  <= rdat_p0[5];
            rhy_kon <= rdat_p0[4:0];
          end
          if (dec_p0.valid) begin
            up        <= dec_p0.up;
            sel_group <= dec_p0.grp;
            sel_sub   <= dec_p0.sub;
            dout      <= rdat_p0;
          end
        end
        SYNC: hold_cnt <= '0;
        // hold stage: one full 18-slot scan starting after the wrap marker
        HOLD: begin
          if (cen) begin
            if (hold_cnt == HOLD_LAST) up <= '0;
            else                       hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/jtopl_wrseq.md
Name: jtopl_wrseq

Overview:
- CPU-side write sequencer for the OPL register file.
- Accepts address and data port writes, queues them in a 4-entry FIFO, and decodes the OPL2 register map into up_* strobes plus sel_group/sel_sub.
- Holds each decoded update for one full 18-slot scan so the time-multiplexed register file captures it when the addressed slot passes.
- Also owns the global registers wave_mode (0x01), rhy_en and rhy_kon (0xBD).

Parameters:
- FIFO_DEPTH, 4: queued data writes; must be a power of two ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- cen  in  1  clock enable, one pulse per slot step
- zero  in  1  slot-counter wrap marker (high during slot 0 on a cen cycle)
- cpu_din  in  8  CPU data bus
- cpu_addr  in  1  0 = index port, 1 = data port
- cpu_wr  in  1  one-clk write strobe
- busy  out  1  FIFO non-empty or sequencer not IDLE
- ovf  out  1  sticky: data write dropped because FIFO was full
- write  out  1  one-clk pulse clearing the register-file update pipeline
- dout  out  8  data presented to register file
- sel_group  out  2  target group
- sel_sub  out  3  target subslot
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon  out  1 each  update strobes
- wave_mode  out  1  reg 0x01 bit5
- rhy_en  out  1  reg 0xBD bit5
- rhy_kon  out  5  reg 0xBD bits4:0

Behaviour:
- Reset (async): all outputs 0, index register 0, FIFO empty, state IDLE. Reset mid-sequence aborts the pending update; strobes drop immediately.
- Clock enable: CPU writes sampled every clk regardless of cen.
- Index port (cpu_wr & !cpu_addr): index <= cpu_din.
- Data port (cpu_wr & cpu_addr): push {index, cpu_din}.
  - Push while full: write dropped, ovf <= 1 (cleared only by rst).
  - Push and pop in the same clk: both happen; count unchanged.
- FSM, states IDLE, DECODE, SYNC, HOLD:
  - IDLE: FIFO non-empty -> pop into {ridx, rdat}; go to DECODE.
  - DECODE (1 clk), by register index:
    - 0x01: wave_mode <= rdat[5]; back to IDLE.
    - 0xBD: rhy_en <= rdat[5], rhy_kon <= rdat[4:0]; back to IDLE.
    - Operator ranges 0x20/0x40/0x60/0x80/0xE0 + off, off = ridx[4:0] ≤ 0x15 and off[2:0] ≤ 5: sel_group = off[4:3], sel_sub = off[2:0]; strobe respectively mult/ksl_tl/ar_dr/sl_rr/wav.
    - Channel ranges 0xA0/0xB0/0xC0 + ch, ch ≤ 8: sel_group = ch/3, sel_sub = ch%3; strobe fnumlo/fnumhi/fbcon.
    - Valid operator or channel index: dout <= rdat, write pulses 1 clk, go to SYNC.
    - Anything else (timers, 0x08, holes, out-of-range): discarded, back to IDLE.
  - SYNC: wait for cen & zero, then go to HOLD. Strobe is already asserted in SYNC.
  - HOLD: count cen pulses; leave after 18 cen pulses. On exit: strobe and write low, sel/dout keep last value, state IDLE. Next pop happens the clk after.
- Exactly one up_* high at a time. Strobes change only on DECODE entry/HOLD exit.
- write is never high while any strobe is high in SYNC/HOLD.
- Latency:
  - Global registers: 2 clk after push into an empty FIFO.
  - Slot registers: take effect within ≤ 36 cen pulses.
- busy is combinational from state/count.

Test Plan:
- Reset: assert rst mid-HOLD -> all strobes, busy, write, rhy_* = 0 immediately; after release, FIFO empty.
- Operator write: write idx 0x43, data 0x3F -> write pulse, then up_ksl_tl = 1, sel_group = 0, sel_sub = 3, dout = 0x3F for exactly 18 cen pulses after the first zero; busy drops after.
- Channel write: idx 0xB5, data 0x2A -> up_fnumhi, sel_group = 1, sel_sub = 2. Idx 0xA9 -> no strobe, busy clears within 3 clk.
- Globals: idx 0xBD, data 0x3F -> rhy_en = 1, rhy_kon = 0x1F two clk later, no up_* or write pulse. Idx 0x01, data 0x20 -> wave_mode = 1.
- FIFO: five back-to-back data writes while busy -> first four applied in order; fifth dropped, ovf = 1. Invalid op offset 0x26 (idx 0x26) -> discarded.
- Simultaneous: push on the same clk as a pop from a full FIFO -> accepted, ovf stays 0.
